// File: rtl/bcd_seq_converter_if.sv
// Handshake and result bundle between a requester and the sequential BCD converter.
// The converter connects through the slave modport and the requester through the master modport.
interface bcd_seq_converter_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg;
  logic                  overflow;

  modport master (
    output start, bin_in, signed_mode,
    input  busy, done, bcd_out, neg, overflow
  );

  modport slave (
    input  start, bin_in, signed_mode,
    output busy, done, bcd_out, neg, overflow
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one operand bit per clock,
// with optional two's-complement input, overflow saturation and start/busy/done handshake.
module bcd_seq_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_seq_converter_if.slave bus
);

  // Digits needed to hold any BIN_W-bit value, plus one guard digit above that.
  localparam int NEED_D = (BIN_W * 30103 + 99999) / 100000;
  localparam int ACC_D  = (NEED_D + 1 > DIGITS + 1) ? NEED_D + 1 : DIGITS + 1;
  localparam int ACC_W  = 4 * ACC_D;
  localparam int OUT_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state_q,    state_d;
  logic [BIN_W-1:0]   mag_q,      mag_d;
  logic [ACC_W-1:0]   acc_q,      acc_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               neg_pend_q, neg_pend_d;
  logic               zero_q,     zero_d;
  logic               carry_q,    carry_d;
  logic [OUT_W-1:0]   bcd_q,      bcd_d;
  logic               neg_q,      neg_d;
  logic               ovf_q,      ovf_d;

  logic [ACC_W-1:0]   acc_adj;

  generate
    for (genvar gi = 0; gi < ACC_D; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                             : acc_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          acc_d   = {acc_adj[ACC_W-2:0], mag_q[BIN_W-1]};
          mag_d   = {mag_q[BIN_W-2:0], 1'b0};
          carry_d = carry_q | acc_adj[ACC_W-1];
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          // All bits consumed: publish results together with the DONE transition.
          if ((|acc_q[ACC_W-1:OUT_W]) || carry_q) begin
            ovf_d = 1'b1;
            bcd_d = ALL_NINES;
          end else begin
            ovf_d = 1'b0;
            bcd_d = acc_q[OUT_W-1:0];
          end
          neg_d   = neg_pend_q & ~zero_q;
          state_d = ST_DONE;
        end
      end

      default: begin
        // IDLE and DONE both accept a new request so back-to-back starts lose no cycle.
        state_d = ST_IDLE;
        if (bus.start) begin
          if (bus.signed_mode && bus.bin_in[BIN_W-1]) begin
            mag_d      = ~bus.bin_in + BIN_W'(1);
            neg_pend_d = 1'b1;
          end else begin
            mag_d      = bus.bin_in;
            neg_pend_d = 1'b0;
          end
          zero_d  = (bus.bin_in == '0);
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = ST_SHIFT;
        end
      end
    endcase
  end

  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.bcd_out  = bcd_q;
  assign bus.neg      = neg_q;
  assign bus.overflow = ovf_q;

endmodule
